hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core (F/D/E/M/W).
- Keeps its own shadow copy of per-stage destination/source tags. Uses them to generate forwarding selects, load-use stalls, branch/jump flushes, and a full-pipeline freeze while a multi-cycle data memory access is outstanding.
- Sits beside the pipeline registers. Drives their stall/flush enables and the execute-stage ALU operand muxes.

Parameters:
- REG_AW, 5, register index width.
- CNT_WIDTH, 32, width of the stall/flush performance counters.
- MEM_TIMEOUT, 16, max memory wait cycles before err_o is raised.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- Rs1D_i  input  REG_AW  rs1 of the instruction in decode.
- Rs2D_i  input  REG_AW  rs2 of the instruction in decode.
- RdD_i  input  REG_AW  rd of the instruction in decode.
- RegWriteD_i  input  1  decode instruction writes rd.
- LoadD_i  input  1  decode instruction is a load (ResultSrc = memory).
- MemD_i  input  1  decode instruction accesses data memory (load or store).
- PCSrcE_i  input  1  branch taken or JAL/JALR resolved in execute.
- mem_ready_i  input  1  data memory completes the access in M this cycle.
- StallF_o  output  1  hold PC.
- StallD_o  output  1  hold the F/D register.
- StallE_o  output  1  hold the D/E register.
- StallM_o  output  1  hold the E/M and M/W registers.
- FlushD_o  output  1  clear the F/D register.
- FlushE_o  output  1  clear the D/E register.
- ForwardAE_o  output  2  SrcA select: 00 reg file, 01 W result, 10 M ALU result.
- ForwardBE_o  output  2  SrcB select, same encoding.
- stall_cnt_o  output  CNT_WIDTH  cycles in which StallF_o was high.
- flush_cnt_o  output  CNT_WIDTH  cycles in which FlushE_o was high.
- err_o  output  1  sticky memory timeout flag.

Behaviour:
- Reset: all tag registers are cleared (RegWrite/Load/Mem = 0, indices = 0), FSM = RUN, counters = 0, err_o = 0.
- While rst is high, all stall/flush outputs are 0 and forward selects are 00.
- Tag pipeline: registers {Rs1, Rs2, Rd, RegWrite, Load, Mem} for E, and {Rd, RegWrite, Mem} for M and W.
- Tag advance rules:
  - D->E captures the decode inputs when StallE_o=0. It captures a bubble (all flags 0) when FlushE_o=1.
  - E->M and M->W advance when StallM_o=0.
  - Freeze holds all tags.
- Forwarding (combinational), for ForwardAE_o:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00.
  - M wins over W. ForwardBE_o uses Rs2E with the same rules.
- Load-use stall: lwStall = LoadE && RdE!=0 && (RdE==Rs1D_i || RdE==Rs2D_i). It gives StallF=StallD=1 and FlushE=1, i.e. a 1-cycle bubble.
- Control hazard: PCSrcE_i gives FlushD=FlushE=1. It overrides lwStall, so StallF/StallD = 0 that cycle.
- FSM states: RUN and MEM_WAIT.
  - freeze = MemM && !mem_ready_i (combinational, in either state).
  - RUN -> MEM_WAIT when freeze.
  - MEM_WAIT -> RUN when mem_ready_i. Stalls drop in that same cycle.
  - While freeze: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0.
  - Freeze has top priority. A pending PCSrcE_i/lwStall is applied in the first cycle after the freeze lifts, because the E tags are held.
- Timeout: a wait counter resets on entry to MEM_WAIT and increments each cycle in MEM_WAIT. When it reaches MEM_TIMEOUT, err_o is set and stays 1 until reset. The FSM keeps waiting.
- Counters: increment by 1 per qualifying cycle and wrap modulo 2^CNT_WIDTH. A freeze cycle counts toward stall_cnt_o.
- Reset asserted mid-wait returns to RUN immediately and discards all tags.

Decomposition:
- Shared package pipeline_pkg:
  - FSM state enum {RUN, MEM_WAIT}.
  - forward select constants FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - stage tag struct {rs1, rs2, rd, regwrite, load, mem}.
- One natural sub-module: fwd_sel. It is the combinational source-vs-M/W comparator and is instantiated twice (A and B).

Test Plan:
- RAW with back-to-back ALU ops: add x5,x1,x2 then sub x6,x5,x3, mem_ready_i=1 -> ForwardAE_o=10 when sub is in E. With a nop inserted between them -> ForwardAE_o=01.
- Load-use: lw x7 then add x8,x7,x1 -> exactly one cycle of StallF=StallD=FlushE=1. Then ForwardAE_o=01. stall_cnt_o=1, flush_cnt_o=1.
- Taken branch in E coinciding with a load-use match in D -> FlushD=FlushE=1, StallF=StallD=0. flush_cnt_o increments by 1.
- lw in M with mem_ready_i low for 3 cycles -> all four stalls high for 3 cycles, flushes 0. Release occurs in the cycle mem_ready_i=1. stall_cnt_o=3.
- mem_ready_i held low for 20 cycles with MEM_TIMEOUT=16 -> err_o rises after 16 wait cycles and stays high. Asserting rst -> err_o=0, FSM in RUN, all outputs 0.
- Writes to x0 (rd=0) followed by a read of x0 -> ForwardAE_o=00 and no load-use stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I hazard/sequencing controller.
// Stage tag bundles, FSM states and forward-select encodings.
package pipeline_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             load;
        logic             mem;
    } stage_tag_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             mem;
    } mw_tag_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } wb_tag_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side inputs and stall/flush/forward outputs of hazard_ctrl.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 32
);
    logic [REG_AW-1:0]    Rs1D_i;
    logic [REG_AW-1:0]    Rs2D_i;
    logic [REG_AW-1:0]    RdD_i;
    logic                 RegWriteD_i;
    logic                 LoadD_i;
    logic                 MemD_i;
    logic                 PCSrcE_i;
    logic                 mem_ready_i;
    logic                 StallF_o;
    logic                 StallD_o;
    logic                 StallE_o;
    logic                 StallM_o;
    logic                 FlushD_o;
    logic                 FlushE_o;
    logic [1:0]           ForwardAE_o;
    logic [1:0]           ForwardBE_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;
    logic                 err_o;

    modport master (
        output Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, LoadD_i, MemD_i,
        output PCSrcE_i, mem_ready_i,
        input  StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o,
        input  ForwardAE_o, ForwardBE_o, stall_cnt_o, flush_cnt_o, err_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, LoadD_i, MemD_i,
        input  PCSrcE_i, mem_ready_i,
        output StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o,
        output ForwardAE_o, ForwardBE_o, stall_cnt_o, flush_cnt_o, err_o
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage source vs M/W destination comparator.
// The M match wins since it holds the younger result.
module fwd_sel
    import pipeline_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] rd_m,
    input  logic          rw_m,
    input  logic [AW-1:0] rd_w,
    input  logic          rw_w,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_REG;
        if (rw_m && rd_m != '0 && rd_m == src)
            sel = FWD_M;
        else if (rw_w && rd_w != '0 && rd_w == src)
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Shadows E/M/W tags to drive forwarding, stalls, flushes and memory freeze.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = REG_W,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic   clk,
    input  logic   rst,
    hazard_ctrl_if.slave bus
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WC_MAX  = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WC_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t               state;
    state_t               state_nx;
    stage_tag_t           tag_d;
    stage_tag_t           tag_e;
    mw_tag_t              tag_m;
    wb_tag_t              tag_w;
    logic [WCW-1:0]       wait_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic                 err;
    logic                 freeze;
    logic                 lw_stall;
    logic                 stall_f;
    logic                 stall_d;
    logic                 stall_em;
    logic                 flush_d;
    logic                 flush_e;

    always_comb begin
        tag_d.rs1      = bus.Rs1D_i;
        tag_d.rs2      = bus.Rs2D_i;
        tag_d.rd       = bus.RdD_i;
        tag_d.regwrite = bus.RegWriteD_i;
        tag_d.load     = bus.LoadD_i;
        tag_d.mem      = bus.MemD_i;
    end

    // Freeze beats redirect, redirect beats load-use.
    always_comb begin
        freeze   = tag_m.mem && !bus.mem_ready_i;
        lw_stall = tag_e.load && tag_e.rd != '0 &&
                   (tag_e.rd == bus.Rs1D_i || tag_e.rd == bus.Rs2D_i);
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (freeze) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
        end else if (bus.PCSrcE_i) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:      if (freeze)          state_nx = MEM_WAIT;
            MEM_WAIT: if (bus.mem_ready_i) state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            tag_e     <= '0;
            tag_m     <= '0;
            tag_w     <= '0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (!stall_em) begin
                tag_e          <= flush_e ? '0 : tag_d;
                tag_m.rd       <= tag_e.rd;
                tag_m.regwrite <= tag_e.regwrite;
                tag_m.mem      <= tag_e.mem;
                tag_w.rd       <= tag_m.rd;
                tag_w.regwrite <= tag_m.regwrite;
            end
            if (state == RUN)
                wait_cnt <= '0;
            else if (wait_cnt != WC_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == MEM_WAIT && wait_cnt == WC_LAST)
                err <= 1'b1;
            stall_cnt <= stall_cnt + CNT_WIDTH'(stall_f);
            flush_cnt <= flush_cnt + CNT_WIDTH'(flush_e);
        end
    end

    fwd_sel #(.AW(REG_AW)) u_fwd_a (
        .src  (tag_e.rs1),
        .rd_m (tag_m.rd),
        .rw_m (tag_m.regwrite),
        .rd_w (tag_w.rd),
        .rw_w (tag_w.regwrite),
        .sel  (bus.ForwardAE_o)
    );

    fwd_sel #(.AW(REG_AW)) u_fwd_b (
        .src  (tag_e.rs2),
        .rd_m (tag_m.rd),
        .rw_m (tag_m.regwrite),
        .rd_w (tag_w.rd),
        .rw_w (tag_w.regwrite),
        .sel  (bus.ForwardBE_o)
    );

    assign bus.StallF_o    = stall_f;
    assign bus.StallD_o    = stall_d;
    assign bus.StallE_o    = stall_em;
    assign bus.StallM_o    = stall_em;
    assign bus.FlushD_o    = flush_d;
    assign bus.FlushE_o    = flush_e;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
    assign bus.err_o       = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// Output vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FwdA,FwdB}.
module tb_hazard_ctrl;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mem;
        logic       pc;
        logic       rdy;
        logic [9:0] exp;
    } row_t;

    localparam logic [9:0] V0  = 10'b0000_00_00_00;
    localparam logic [9:0] VLU = 10'b1100_01_00_00;
    localparam logic [9:0] VBR = 10'b0000_11_00_00;
    localparam logic [9:0] VFZ = 10'b1111_00_00_00;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    logic [9:0] sb [$];

    hazard_ctrl_if #(.REG_AW(5), .CNT_WIDTH(32)) bus ();

    hazard_ctrl #(
        .REG_AW(5),
        .CNT_WIDTH(32),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw,
                                input logic ld, input logic mem,
                                input logic pc, input logic rdy,
                                input logic [9:0] exp);
        row_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rw = rw; r.ld = ld; r.mem = mem;
        r.pc = pc; r.rdy = rdy; r.exp = exp;
        return r;
    endfunction

    function automatic row_t nop(input logic pc, input logic rdy,
                                 input logic [9:0] exp);
        return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, pc, rdy, exp);
    endfunction

    function automatic row_t lw7();
        return mk(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, V0);
    endfunction

    function automatic logic [9:0] obs();
        return {bus.StallF_o, bus.StallD_o, bus.StallE_o, bus.StallM_o,
                bus.FlushD_o, bus.FlushE_o, bus.ForwardAE_o, bus.ForwardBE_o};
    endfunction

    task automatic drv(input row_t x);
        bus.Rs1D_i      = x.rs1;
        bus.Rs2D_i      = x.rs2;
        bus.RdD_i       = x.rd;
        bus.RegWriteD_i = x.rw;
        bus.LoadD_i     = x.ld;
        bus.MemD_i      = x.mem;
        bus.PCSrcE_i    = x.pc;
        bus.mem_ready_i = x.rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drv(nop(1'b0, 1'b1, V0));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] got, e;
        rst = 1'b1;
        drv(mk(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, V0));
        sb.push_back(V0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = obs(); e = sb.pop_front(); vectors++;
        if (got !== e) begin
            $display("FAIL reset_outputs got=%b exp=%b", got, e); errors++;
        end
        vectors++;
        if (bus.err_o !== 1'b0) begin
            $display("FAIL reset_err got=%b exp=0", bus.err_o); errors++;
        end
        vectors++;
        if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     bus.stall_cnt_o, bus.flush_cnt_o); errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_raw_forward();
        row_t rows [$];
        logic [9:0] got, e;
        idle(3);
        rows.push_back(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(mk(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, 10'b0000_00_10_00));
        rows.push_back(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, V0));
        rows.push_back(mk(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, 10'b0000_00_01_01));
        rows.push_back(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(mk(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(mk(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, 10'b0000_00_10_00));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL raw[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t rows [$];
        logic [9:0] got, e;
        logic [31:0] s0, f0;
        idle(3);
        s0 = bus.stall_cnt_o; f0 = bus.flush_cnt_o;
        rows.push_back(lw7());
        rows.push_back(mk(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, VLU));
        rows.push_back(mk(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, 10'b0000_00_01_00));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.stall_cnt_o - s0 !== 32'd1) begin
            $display("FAIL load_use_stall_cnt got=%0d exp=1", bus.stall_cnt_o - s0);
            errors++;
        end
        vectors++;
        if (bus.flush_cnt_o - f0 !== 32'd1) begin
            $display("FAIL load_use_flush_cnt got=%0d exp=1", bus.flush_cnt_o - f0);
            errors++;
        end
    endtask

    task automatic test_branch_over_lw();
        row_t rows [$];
        logic [9:0] got, e;
        logic [31:0] s0, f0;
        idle(3);
        s0 = bus.stall_cnt_o; f0 = bus.flush_cnt_o;
        rows.push_back(lw7());
        rows.push_back(mk(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, VBR));
        rows.push_back(nop(1'b0, 1'b1, V0));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.flush_cnt_o - f0 !== 32'd1) begin
            $display("FAIL branch_flush_cnt got=%0d exp=1", bus.flush_cnt_o - f0);
            errors++;
        end
        vectors++;
        if (bus.stall_cnt_o - s0 !== 32'd0) begin
            $display("FAIL branch_stall_cnt got=%0d exp=0", bus.stall_cnt_o - s0);
            errors++;
        end
    endtask

    task automatic test_mem_freeze();
        row_t rows [$];
        logic [9:0] got, e;
        logic [31:0] s0, f0;
        idle(3);
        s0 = bus.stall_cnt_o; f0 = bus.flush_cnt_o;
        rows.push_back(lw7());
        rows.push_back(nop(1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b0, VFZ));
        rows.push_back(nop(1'b1, 1'b0, VFZ));
        rows.push_back(nop(1'b0, 1'b0, VFZ));
        rows.push_back(nop(1'b1, 1'b1, VBR));
        rows.push_back(nop(1'b0, 1'b1, V0));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL freeze[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.stall_cnt_o - s0 !== 32'd3) begin
            $display("FAIL freeze_stall_cnt got=%0d exp=3", bus.stall_cnt_o - s0);
            errors++;
        end
        vectors++;
        if (bus.flush_cnt_o - f0 !== 32'd1) begin
            $display("FAIL freeze_flush_cnt got=%0d exp=1", bus.flush_cnt_o - f0);
            errors++;
        end
    endtask

    task automatic test_timeout();
        row_t rows [$];
        logic [9:0] got, e;
        idle(3);
        rows.push_back(lw7());
        rows.push_back(nop(1'b0, 1'b1, V0));
        for (int k = 0; k < 20; k++) rows.push_back(nop(1'b0, 1'b0, VFZ));
        rows.push_back(nop(1'b0, 1'b1, V0));
        rows.push_back(lw7());
        rows.push_back(nop(1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b0, VFZ));
        rows.push_back(nop(1'b0, 1'b0, VFZ));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL timeout[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            if (i == 11) begin
                vectors++;
                if (bus.err_o !== 1'b0) begin
                    $display("FAIL err_early got=%b exp=0", bus.err_o); errors++;
                end
            end
            if (i == 21 || i == 22 || i == 26) begin
                vectors++;
                if (bus.err_o !== 1'b1) begin
                    $display("FAIL err_sticky[%0d] got=%b exp=1", i, bus.err_o);
                    errors++;
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drv(mk(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, V0));
        sb.push_back(V0);
        @(negedge clk);
        got = obs(); e = sb.pop_front(); vectors++;
        if (got !== e) begin
            $display("FAIL rst_wait_outputs got=%b exp=%b", got, e); errors++;
        end
        vectors++;
        if (bus.err_o !== 1'b0) begin
            $display("FAIL rst_wait_err got=%b exp=0", bus.err_o); errors++;
        end
        vectors++;
        if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
            $display("FAIL rst_wait_cnt got=%0d/%0d exp=0/0",
                     bus.stall_cnt_o, bus.flush_cnt_o); errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drv(nop(1'b0, 1'b0, V0));
        sb.push_back(V0);
        @(negedge clk);
        got = obs(); e = sb.pop_front(); vectors++;
        if (got !== e) begin
            $display("FAIL post_rst_run got=%b exp=%b", got, e); errors++;
        end
        @(posedge clk); #1;
        idle(3);
    endtask

    task automatic test_x0();
        row_t rows [$];
        logic [9:0] got, e;
        idle(3);
        rows.push_back(mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, V0));
        rows.push_back(mk(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V0));
        rows.push_back(nop(1'b0, 1'b1, V0));
        foreach (rows[i]) begin
            drv(rows[i]); sb.push_back(rows[i].exp);
            @(negedge clk);
            got = obs(); e = sb.pop_front(); vectors++;
            if (got !== e) begin
                $display("FAIL x0[%0d] got=%b exp=%b", i, got, e); errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        drv(nop(1'b0, 1'b1, V0));
        #1;
        test_reset();
        test_raw_forward();
        test_load_use();
        test_branch_over_lw();
        test_mem_freeze();
        test_timeout();
        test_x0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
